trivium_ctrl: RTL and testbench
===============================

# trivium_ctrl

Sequencing controller for the Trivium keystream core. It latches an 80-bit key and 80-bit IV on `start`, loads them into the core, and steps the core through the mandatory warm-up without exposing keystream. It then packs keystream bits into OUT_W-bit words and delivers them over a valid/ready handshake, stalling the core under backpressure. It sits between the core and any consumer, such as a byte-wise XOR cipher stage.

## Interface
- `WARMUP`, default 1152: number of discarded warm-up steps after load.
- `OUT_W`, default 8: keystream word width, ≥2.
- `MAX_WORDS`, default 65536: word limit per key/IV. Used only with `TRIVIUM_CTRL_LIMIT_EN`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: 1-cycle pulse; latch `key_in` / `iv_in` and (re)start sequencing.
- `stop` in 1: abort to IDLE.
- `key_in` in 80: key, sampled when `start`=1.
- `iv_in` in 80: IV, sampled when `start`=1.
- `core_key` out 80: latched key to core.
- `core_iv` out 80: latched IV to core.
- `core_load` out 1: core loads key/IV state on this edge.
- `core_step` out 1: core advances one step on this edge.
- `core_ks` in 1: core keystream bit, combinational from current core state.
- `ks_data` out OUT_W: keystream word; first generated bit in bit 0.
- `ks_valid` out 1: `ks_data` valid.
- `ks_ready` in 1: consumer accepts the word when `ks_valid` and `ks_ready` are both 1.
- `busy` out 1: state is not IDLE.
- `exhausted` out 1: word limit reached; a rekey is required.

## Operation
- States: IDLE, LOAD, WARMUP, GEN, DONE.
- IDLE: `core_step`=0, `core_load`=0. `start` moves to LOAD.
- LOAD: one cycle with `core_load`=1, then WARMUP. Clears the warm-up counter, bit counter and word counter.
- WARMUP: `core_step`=1 every cycle for exactly WARMUP cycles. `core_ks` is ignored. The counter runs 0..WARMUP-1; on the last step the state moves to GEN.
- GEN, collection: when `core_step`=1, shift `core_ks` into the collector at position `bit_cnt` (0..OUT_W-1).
- GEN, word completion: on the step with `bit_cnt`=OUT_W-1, the completed word is written to the `ks_data` register, `ks_valid` is set, and `bit_cnt` wraps to 0.
- GEN, step gating: `core_step` = (`bit_cnt` != OUT_W-1) OR !`ks_valid` OR `ks_ready`. The core therefore pauses only when the next word would overwrite an unaccepted one.
- Handshake: `ks_valid` clears on acceptance unless a new word completes on the same edge; in that case it stays 1 and `ks_data` takes the new word. `ks_data` is stable while `ks_valid`=1 and `ks_ready`=0.
- `start` in any state, including mid-WARMUP or GEN:
  - relatch key/IV and go to LOAD;
  - drop `ks_valid`;
  - discard any partial word;
  - clear `exhausted`.
- `stop` in any state, with `start`=0: go to IDLE and drop `ks_valid`. `start` wins over `stop` when both are asserted.
- DONE is reachable only with the macro (see Configuration). `core_step`=0 and `exhausted`=1 in DONE. Leave DONE via `start` or `stop`.
- Counters:
  - warm-up counter: ceil(log2(WARMUP+1)) bits;
  - bit counter: ceil(log2(OUT_W)) bits;
  - word counter: ceil(log2(MAX_WORDS+1)) bits, saturating; never wraps.
- `core_load` and `core_step` are never asserted in the same cycle.

## Timing
- Reset values:
  - `ks_valid`=0, `ks_data`=0, `core_load`=0, `core_step`=0, `busy`=0, `exhausted`=0;
  - `core_key`=0, `core_iv`=0;
  - state IDLE; all counters 0.
- `start` sampled at edge E0 gives:
  - `core_load`=1 in the cycle after E0; the core loads at E1;
  - warm-up steps at E2..E(WARMUP+1);
  - GEN steps from E(WARMUP+2);
  - first `ks_valid` after E(WARMUP+OUT_W+1). With defaults this is 1161 cycles after E0.
- Sustained throughput with `ks_ready`=1: one word per OUT_W cycles, with no bubbles.
- `busy` goes high the cycle after `start` is sampled. It goes low the cycle after `stop` is sampled.

## Configuration
- Macro `TRIVIUM_CTRL_LIMIT_EN`.
- Defined:
  - the word counter increments on every accepted word;
  - when it reaches MAX_WORDS, the state moves from GEN to DONE and `exhausted`=1;
  - a partially collected word is discarded;
  - no further `core_step`.
- Undefined: no word counter, DONE unreachable, `exhausted` tied 0, and generation is unlimited.

## Test plan
- Reset: assert `rst`=0 mid-GEN → all outputs at reset values immediately. After release: IDLE, `core_step`=0.
- Known-answer check with key=80'h9719CFC92A9FF688F9AA and IV=80'hECBB76B09AFF71D0D151, then `start`:
  - `core_load` pulses once, and `core_step` is high for exactly 1152 cycles;
  - `ks_valid` rises 1161 cycles after E0;
  - the first 16 words match the behavioural Trivium model, LSB-first.
- Backpressure: hold `ks_ready`=0 for 20 cycles after the first word → `ks_data` stable, `core_step` drops after 7 further steps, no bit lost. After release, the words continue to match the model.
- Mid-warm-up restart: pulse `start` with a new IV at warm-up step 500 → a fresh `core_load`, then 1152 new steps. The output matches the model for the new IV only.
- Stop/start precedence: `stop` during GEN → IDLE next cycle, `ks_valid`=0. `start` and `stop` in the same cycle → LOAD.
- Word limit: with `TRIVIUM_CTRL_LIMIT_EN` and MAX_WORDS=4 → after 4 accepted words, `exhausted`=1, `core_step`=0, and no fifth `ks_valid`. Without the macro, the bench sees a fifth word and `exhausted` stays 0.

Source files
------------

// File: rtl/trivium_ctrl.sv
// trivium_ctrl: sequencing controller for a Trivium keystream core.
// On start it latches the key and IV, pulses core_load, and runs WARMUP
// silent core steps. It then packs keystream bits LSB-first into OUT_W-bit
// words, which are delivered over a valid/ready port. The core is stalled
// only when the next completed word would overwrite an unaccepted one.
// Optional feature macro: TRIVIUM_CTRL_LIMIT_EN. When it is defined, the
// number of words delivered per key/IV is capped at MAX_WORDS, after which
// the controller parks in DONE with exhausted=1.
module trivium_ctrl #(
    parameter int WARMUP    = 1152,
    parameter int OUT_W     = 8,
    parameter int MAX_WORDS = 65536
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [79:0]      key_in,
    input  logic [79:0]      iv_in,
    output logic [79:0]      core_key,
    output logic [79:0]      core_iv,
    output logic             core_load,
    output logic             core_step,
    input  logic             core_ks,
    output logic [OUT_W-1:0] ks_data,
    output logic             ks_valid,
    input  logic             ks_ready,
    output logic             busy,
    output logic             exhausted
);

    localparam int WU_W = $clog2(WARMUP + 1);
    localparam int BC_W = $clog2(OUT_W);
    localparam logic [WU_W-1:0] WU_LAST = WU_W'(WARMUP - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(OUT_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_WARM = 3'd2,
        ST_GEN  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [WU_W-1:0]    wu_cnt_q, wu_cnt_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [OUT_W-2:0]   col_q, col_d;
    logic [OUT_W-1:0]   ks_data_q, ks_data_d;
    logic               ks_valid_q, ks_valid_d;
    logic [79:0]        key_q, key_d;
    logic [79:0]        iv_q, iv_d;
    logic               exh_q, exh_d;

    logic               core_load_s;
    logic               core_step_s;
    logic               busy_s;
    logic               accept_s;
    logic               limit_hit_s;

    assign accept_s = ks_valid_q & ks_ready;

`ifdef TRIVIUM_CTRL_LIMIT_EN
    localparam int WC_W = $clog2(MAX_WORDS + 1);
    localparam logic [WC_W-1:0] WC_MAX  = WC_W'(MAX_WORDS);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MAX_WORDS - 1);

    logic [WC_W-1:0]    wc_q, wc_d;

    // The word that takes the count to MAX_WORDS ends generation for this key/IV.
    assign limit_hit_s = (state_q == ST_GEN) && accept_s && (wc_q == WC_LAST);

    // Word counter next value: cleared on (re)load, saturating count of accepted words.
    always_comb begin
        wc_d = wc_q;
        if (start) begin
            wc_d = {WC_W{1'b0}};
        end else if (state_q == ST_LOAD) begin
            wc_d = {WC_W{1'b0}};
        end else if ((state_q == ST_GEN) && accept_s && (wc_q != WC_MAX)) begin
            wc_d = wc_q + WC_W'(1);
        end else begin
            wc_d = wc_q;
        end
    end

    // Word counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wc_q <= {WC_W{1'b0}};
        end else begin
            wc_q <= wc_d;
        end
    end
`else
    assign limit_hit_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: start beats stop, and both beat normal sequencing.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_LOAD;
        end else if (stop) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_LOAD: state_d = ST_WARM;
                ST_WARM: begin
                    if (wu_cnt_q == WU_LAST) begin
                        state_d = ST_GEN;
                    end else begin
                        state_d = ST_WARM;
                    end
                end
                ST_GEN: begin
                    if (limit_hit_s) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_GEN;
                    end
                end
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Core control and busy decode. In GEN the core pauses only when the word
    // it would complete has nowhere to go.
    always_comb begin
        core_load_s = 1'b0;
        core_step_s = 1'b0;
        busy_s      = 1'b1;
        case (state_q)
            ST_IDLE: busy_s      = 1'b0;
            ST_LOAD: core_load_s = 1'b1;
            ST_WARM: core_step_s = 1'b1;
            ST_GEN:  core_step_s = (bit_cnt_q != BC_LAST) || !ks_valid_q || ks_ready;
            ST_DONE: core_step_s = 1'b0;
            default: busy_s      = 1'b0;
        endcase
    end

    // Datapath next values: key/IV latch, warm-up count, bit collection, word handshake.
    always_comb begin
        key_d      = key_q;
        iv_d       = iv_q;
        wu_cnt_d   = wu_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        col_d      = col_q;
        ks_data_d  = ks_data_q;
        ks_valid_d = ks_valid_q;
        exh_d      = exh_q;
        if (start) begin
            key_d      = key_in;
            iv_d       = iv_in;
            ks_valid_d = 1'b0;
            bit_cnt_d  = {BC_W{1'b0}};
            col_d      = {(OUT_W-1){1'b0}};
            exh_d      = 1'b0;
        end else if (stop) begin
            ks_valid_d = 1'b0;
            bit_cnt_d  = {BC_W{1'b0}};
        end else begin
            case (state_q)
                ST_LOAD: begin
                    wu_cnt_d  = {WU_W{1'b0}};
                    bit_cnt_d = {BC_W{1'b0}};
                    col_d     = {(OUT_W-1){1'b0}};
                end
                ST_WARM: wu_cnt_d = wu_cnt_q + WU_W'(1);
                ST_GEN: begin
                    if (limit_hit_s) begin
                        // Last permitted word accepted: drop any partial word.
                        ks_valid_d = 1'b0;
                        bit_cnt_d  = {BC_W{1'b0}};
                        exh_d      = 1'b1;
                    end else begin
                        if (accept_s) begin
                            ks_valid_d = 1'b0;
                        end else begin
                            ks_valid_d = ks_valid_q;
                        end
                        if (core_step_s) begin
                            if (bit_cnt_q == BC_LAST) begin
                                // Top bit comes straight from the core; a new
                                // word overrides a same-edge acceptance.
                                ks_data_d  = {core_ks, col_q};
                                ks_valid_d = 1'b1;
                                bit_cnt_d  = {BC_W{1'b0}};
                            end else begin
                                col_d[bit_cnt_q] = core_ks;
                                bit_cnt_d        = bit_cnt_q + BC_W'(1);
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q;
                        end
                    end
                end
                default: ks_valid_d = ks_valid_q;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_q      <= 80'd0;
            iv_q       <= 80'd0;
            wu_cnt_q   <= {WU_W{1'b0}};
            bit_cnt_q  <= {BC_W{1'b0}};
            col_q      <= {(OUT_W-1){1'b0}};
            ks_data_q  <= {OUT_W{1'b0}};
            ks_valid_q <= 1'b0;
            exh_q      <= 1'b0;
        end else begin
            key_q      <= key_d;
            iv_q       <= iv_d;
            wu_cnt_q   <= wu_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            col_q      <= col_d;
            ks_data_q  <= ks_data_d;
            ks_valid_q <= ks_valid_d;
            exh_q      <= exh_d;
        end
    end

    assign core_key  = key_q;
    assign core_iv   = iv_q;
    assign core_load = core_load_s;
    assign core_step = core_step_s;
    assign ks_data   = ks_data_q;
    assign ks_valid  = ks_valid_q;
    assign busy      = busy_s;
    assign exhausted = exh_q;

endmodule

// File: tb/tb_trivium_ctrl.sv
// Self-checking bench for trivium_ctrl. A behavioural Trivium core is driven
// by the DUT's core_load/core_step. Expected keystream words are computed
// independently, as 1152 discarded steps followed by LSB-first packing, and
// are queued at start. They are popped as the DUT hands words over.
module tb_trivium_ctrl;

    localparam int W         = 8;
    localparam int WU        = 1152;
    localparam int FIRST_LAT = WU + W + 1;
`ifdef TRIVIUM_CTRL_LIMIT_EN
    localparam int CAP = 4;
`else
    localparam int CAP = 1000;
`endif

    localparam logic [79:0] K1  = 80'h9719CFC92A9FF688F9AA;
    localparam logic [79:0] IV1 = 80'hECBB76B09AFF71D0D151;
    localparam logic [79:0] K2  = 80'h0123456789ABCDEF0011;
    localparam logic [79:0] IV2 = 80'hFEDCBA98765432100ABC;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic [79:0]   key_in = 80'd0;
    logic [79:0]   iv_in = 80'd0;
    logic [79:0]   core_key;
    logic [79:0]   core_iv;
    logic          core_load;
    logic          core_step;
    logic          core_ks;
    logic [W-1:0]  ks_data;
    logic          ks_valid;
    logic          ks_ready = 1'b0;
    logic          busy;
    logic          exhausted;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [W-1:0]  exp_q[$];
    logic [288:1]  core_s = {288{1'b0}};

    always #5 clk = ~clk;

    trivium_ctrl #(.WARMUP(WU), .OUT_W(W), .MAX_WORDS(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .key_in(key_in), .iv_in(iv_in), .core_key(core_key), .core_iv(core_iv),
        .core_load(core_load), .core_step(core_step), .core_ks(core_ks),
        .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
        .busy(busy), .exhausted(exhausted)
    );

    function automatic logic [288:1] trv_load(input logic [79:0] k, input logic [79:0] v);
        logic [288:1] s;
        s = {288{1'b0}};
        for (int i = 1; i <= 80; i++) begin
            s[i]      = k[i-1];
            s[93 + i] = v[i-1];
        end
        s[286] = 1'b1;
        s[287] = 1'b1;
        s[288] = 1'b1;
        return s;
    endfunction

    function automatic logic trv_z(input logic [288:1] s);
        return s[66] ^ s[93] ^ s[162] ^ s[177] ^ s[243] ^ s[288];
    endfunction

    function automatic logic [288:1] trv_next(input logic [288:1] s);
        logic t1, t2, t3;
        t1 = s[66] ^ s[93] ^ (s[91] & s[92]) ^ s[171];
        t2 = s[162] ^ s[177] ^ (s[175] & s[176]) ^ s[264];
        t3 = s[243] ^ s[288] ^ (s[286] & s[287]) ^ s[69];
        return {s[287:178], t2, s[176:94], t1, s[92:1], t3};
    endfunction

    function automatic int capn(input int n);
        return (n < CAP) ? n : CAP;
    endfunction

    // Behavioural Trivium core.
    always @(posedge clk) begin
        if (core_load) core_s <= trv_load(core_key, core_iv);
        else if (core_step) core_s <= trv_next(core_s);
    end
    assign core_ks = trv_z(core_s);

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [79:0] k, input logic [79:0] v);
        key_in = k;
        iv_in  = v;
        start  = 1'b1;
        step();
        start  = 1'b0;
    endtask

    task automatic push_expected(input logic [79:0] k, input logic [79:0] v, input int n);
        logic [288:1] s;
        logic [W-1:0] w;
        s = trv_load(k, v);
        for (int i = 0; i < WU; i++) s = trv_next(s);
        for (int j = 0; j < n; j++) begin
            for (int b = 0; b < W; b++) begin
                w[b] = trv_z(s);
                s    = trv_next(s);
            end
            exp_q.push_back(w);
        end
    endtask

    // Called right after start was sampled (E0); runs until ks_valid or budget.
    task automatic wait_first_word(output int c, output int loads, output int steps, output int both);
        c = 0; loads = core_load ? 1 : 0; steps = 0; both = 0;
        while (!ks_valid && c < 3000) begin
            step();
            c++;
            if (core_load) loads++;
            if (core_step && c <= WU) steps++;
            if (core_load && core_step) both++;
        end
    endtask

    task automatic consume(input int n, input int budget, input string tag, output int t);
        int got;
        logic [W-1:0] e;
        got = 0; t = 0;
        ks_ready = 1'b1;
        while (got < n && t < budget) begin
            if (ks_valid && ks_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s word %0d: got %h, expected none queued", tag, got, ks_data);
                end else begin
                    e = exp_q.pop_front();
                    if (ks_data !== e) begin
                        n_err++;
                        $display("FAIL %s word %0d: got %h expected %h", tag, got, ks_data, e);
                    end
                end
                got++;
            end
            step();
            t++;
        end
        n_cmp++;
        if (got != n) begin
            n_err++;
            $display("FAIL %s word count: got %0d expected %0d", tag, got, n);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({core_key, core_iv, ks_data, ks_valid, core_load, core_step, busy, exhausted} !== {(160+W+5){1'b0}}) begin
            n_err++;
            $display("FAIL reset_values: got key=%h iv=%h data=%h v=%b ld=%b st=%b busy=%b ex=%b expected all 0",
                     core_key, core_iv, ks_data, ks_valid, core_load, core_step, busy, exhausted);
        end
        repeat (3) step();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({busy, core_step, core_load} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_release: got busy/step/load=%b expected 000", {busy, core_step, core_load});
        end
    endtask

    task automatic test_kat();
        int c, loads, steps, both, t, n;
        exp_q.delete();
        ks_ready = 1'b1;
        n = capn(16);
        push_expected(K1, IV1, n);
        do_start(K1, IV1);
        n_cmp++;
        if ({core_load, busy, core_step} !== 3'b110) begin
            n_err++;
            $display("FAIL kat_load_cycle: got load/busy/step=%b expected 110", {core_load, busy, core_step});
        end
        n_cmp++;
        if (core_key !== K1 || core_iv !== IV1) begin
            n_err++;
            $display("FAIL kat_latch: got %h/%h expected %h/%h", core_key, core_iv, K1, IV1);
        end
        wait_first_word(c, loads, steps, both);
        n_cmp++;
        if (c != FIRST_LAT) begin n_err++; $display("FAIL kat_latency: got %0d expected %0d", c, FIRST_LAT); end
        n_cmp++;
        if (loads != 1) begin n_err++; $display("FAIL kat_load_pulses: got %0d expected 1", loads); end
        n_cmp++;
        if (steps != WU) begin n_err++; $display("FAIL kat_warmup_steps: got %0d expected %0d", steps, WU); end
        n_cmp++;
        if (both != 0) begin n_err++; $display("FAIL kat_load_step_overlap: got %0d expected 0", both); end
        consume(n, 400, "kat", t);
        n_cmp++;
        if (t != (n - 1) * W + 1) begin
            n_err++;
            $display("FAIL kat_throughput: got %0d cycles expected %0d", t, (n - 1) * W + 1);
        end
    endtask

    task automatic test_backpressure();
        int c, loads, steps, both, t, n, sc, bad;
        logic [W-1:0] held;
        exp_q.delete();
        ks_ready = 1'b0;
        n = capn(16);
        push_expected(K2, IV1, n);
        do_start(K2, IV1);
        wait_first_word(c, loads, steps, both);
        n_cmp++;
        if (c != FIRST_LAT) begin n_err++; $display("FAIL bp_latency: got %0d expected %0d", c, FIRST_LAT); end
        held = ks_data; sc = 0; bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (core_step) sc++;
            if (!ks_valid || ks_data !== held) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL bp_data_stable: got %0d changed cycles expected 0", bad); end
        n_cmp++;
        if (sc != W - 1) begin n_err++; $display("FAIL bp_steps_before_stall: got %0d expected %0d", sc, W - 1); end
        consume(n, 600, "bp", t);
    endtask

    task automatic test_restart();
        int c, loads, steps, both, t, sc;
        exp_q.delete();
        ks_ready = 1'b1;
        push_expected(K1, IV2, capn(8));
        do_start(K1, IV1);
        sc = 0; c = 0;
        while (sc < 500 && c < 2000) begin
            if (core_step) sc++;
            step();
            c++;
        end
        n_cmp++;
        if (sc != 500) begin n_err++; $display("FAIL rs_warmup_progress: got %0d expected 500", sc); end
        do_start(K1, IV2);
        n_cmp++;
        if (core_load !== 1'b1 || core_iv !== IV2) begin
            n_err++;
            $display("FAIL rs_reload: got load=%b iv=%h expected 1/%h", core_load, core_iv, IV2);
        end
        wait_first_word(c, loads, steps, both);
        n_cmp++;
        if (c != FIRST_LAT || loads != 1 || steps != WU) begin
            n_err++;
            $display("FAIL rs_sequence: got lat=%0d loads=%0d steps=%0d expected %0d/1/%0d", c, loads, steps, FIRST_LAT, WU);
        end
        consume(capn(8), 200, "rs", t);
    endtask

    task automatic test_stop_start();
        int c, loads, steps, both, t;
        exp_q.delete();
        ks_ready = 1'b0;
        do_start(K2, IV2);
        wait_first_word(c, loads, steps, both);
        stop = 1'b1;
        step();
        stop = 1'b0;
        n_cmp++;
        if ({busy, ks_valid, core_step} !== 3'b000) begin
            n_err++;
            $display("FAIL stop_to_idle: got busy/valid/step=%b expected 000", {busy, ks_valid, core_step});
        end
        push_expected(K2, IV1, capn(2));
        key_in = K2; iv_in = IV1;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        n_cmp++;
        if ({core_load, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL start_beats_stop: got load/busy=%b expected 11", {core_load, busy});
        end
        consume(capn(2), 2000, "ss", t);
    endtask

    task automatic test_word_limit();
        int t;
`ifdef TRIVIUM_CTRL_LIMIT_EN
        int bad;
`endif
        exp_q.delete();
        ks_ready = 1'b1;
        push_expected(K2, IV2, 5);
        do_start(K2, IV2);
        consume(4, 2000, "lim", t);
`ifdef TRIVIUM_CTRL_LIMIT_EN
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (ks_valid || core_step) bad++;
            step();
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL lim_no_fifth: got %0d active cycles expected 0", bad); end
        n_cmp++;
        if ({exhausted, busy} !== 2'b11) begin
            n_err++;
            $display("FAIL lim_exhausted: got ex/busy=%b expected 11", {exhausted, busy});
        end
`else
        consume(1, 50, "lim5", t);
        n_cmp++;
        if (exhausted !== 1'b0) begin n_err++; $display("FAIL lim_unlimited: got ex=%b expected 0", exhausted); end
`endif
    endtask

    task automatic test_async_reset();
        int t;
        exp_q.delete();
        ks_ready = 1'b1;
        push_expected(K1, IV1, 1);
        do_start(K1, IV1);
        consume(1, 2000, "ar", t);
        #2 rst = 1'b0;
        #1;
        n_cmp++;
        if ({core_key, core_iv, ks_data, ks_valid, core_load, core_step, busy, exhausted} !== {(160+W+5){1'b0}}) begin
            n_err++;
            $display("FAIL async_reset: got key=%h iv=%h data=%h v=%b ld=%b st=%b busy=%b ex=%b expected all 0",
                     core_key, core_iv, ks_data, ks_valid, core_load, core_step, busy, exhausted);
        end
        step();
        step();
        rst = 1'b1;
        step();
        n_cmp++;
        if ({busy, core_step, core_load, ks_valid} !== 4'b0000) begin
            n_err++;
            $display("FAIL async_reset_release: got busy/step/load/valid=%b expected 0000",
                     {busy, core_step, core_load, ks_valid});
        end
    endtask

    initial begin
        test_reset();
        test_kat();
        test_backpressure();
        test_restart();
        test_stop_start();
        test_word_limit();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
